// File: rtl/csr_counter_ids_pins.sv
// CSR side-bus peripheral: read-only ID registers, 64-bit cycle/instret counters
// and a small bank of software-writable output pins.
module csr_counter_ids_pins #(
    parameter logic [31:0] ISA              = 32'h40001104,
    parameter logic [11:0] IDS_BASE_ADDR    = 12'hFC0,
    parameter logic [31:0] KHZ              = 32'd10,
    parameter logic [11:0] PINS_BASE_ADDR   = 12'hBC1,
    parameter int          PINS_COUNT       = 1,
    parameter logic [31:0] PINS_RESET_VALUE = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           wdata,
    input  logic [11:0]           addr,
    output logic [31:0]           rdata,
    output logic                  valid,
    input  logic                  retired,
    output logic [PINS_COUNT-1:0] pins
);

    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
    localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_TIME      = 12'hC01;
    localparam logic [11:0] ADDR_TIMEH     = 12'hC81;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

    logic [63:0]           mcycle_r;
    logic [63:0]           minstret_r;
    logic [PINS_COUNT-1:0] pins_r;
    logic [31:0]           rdata_r;

    logic                  hit_s;
    logic [31:0]           rd_val_s;
    logic [31:0]           pins_ext_s;
    logic                  wr_mcycle_lo_s;
    logic                  wr_mcycle_hi_s;
    logic                  wr_minstret_lo_s;
    logic                  wr_minstret_hi_s;
    logic                  wr_pins_s;

    // Zero-extend the pin bank to a full CSR word
    always_comb begin
        pins_ext_s                 = 32'h0;
        pins_ext_s[PINS_COUNT-1:0] = pins_r;
    end

    // Address decode and read-data mux; time/timeh alias the cycle counter
    always_comb begin
        hit_s    = 1'b1;
        rd_val_s = 32'h0;
        case (addr)
            ADDR_MISA:                                rd_val_s = ISA;
            ADDR_MVENDORID, ADDR_MARCHID,
            ADDR_MIMPID, ADDR_MHARTID:                rd_val_s = 32'h0;
            IDS_BASE_ADDR:                            rd_val_s = KHZ;
            ADDR_MCYCLE, ADDR_CYCLE, ADDR_TIME:       rd_val_s = mcycle_r[31:0];
            ADDR_MCYCLEH, ADDR_CYCLEH, ADDR_TIMEH:    rd_val_s = mcycle_r[63:32];
            ADDR_MINSTRET, ADDR_INSTRET:              rd_val_s = minstret_r[31:0];
            ADDR_MINSTRETH, ADDR_INSTRETH:            rd_val_s = minstret_r[63:32];
            PINS_BASE_ADDR:                           rd_val_s = pins_ext_s;
            default: begin
                hit_s    = 1'b0;
                rd_val_s = 32'h0;
            end
        endcase
    end

    assign valid            = hit_s;
    assign wr_mcycle_lo_s   = write && (addr == ADDR_MCYCLE);
    assign wr_mcycle_hi_s   = write && (addr == ADDR_MCYCLEH);
    assign wr_minstret_lo_s = write && (addr == ADDR_MINSTRET);
    assign wr_minstret_hi_s = write && (addr == ADDR_MINSTRETH);
    assign wr_pins_s        = write && (addr == PINS_BASE_ADDR);

    // Cycle counter: a half-word write replaces that half and suppresses the increment
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle_r <= 64'h0;
        end else if (wr_mcycle_lo_s) begin
            mcycle_r[31:0] <= wdata;
        end else if (wr_mcycle_hi_s) begin
            mcycle_r[63:32] <= wdata;
        end else begin
            mcycle_r <= mcycle_r + 64'd1;
        end
    end

    // Retired-instruction counter, same write-over-increment priority
    always_ff @(posedge clk) begin
        if (rst) begin
            minstret_r <= 64'h0;
        end else if (wr_minstret_lo_s) begin
            minstret_r[31:0] <= wdata;
        end else if (wr_minstret_hi_s) begin
            minstret_r[63:32] <= wdata;
        end else if (retired) begin
            minstret_r <= minstret_r + 64'd1;
        end else begin
            minstret_r <= minstret_r;
        end
    end

    // Output pin register
    always_ff @(posedge clk) begin
        if (rst) begin
            pins_r <= PINS_RESET_VALUE[PINS_COUNT-1:0];
        end else if (wr_pins_s) begin
            pins_r <= wdata[PINS_COUNT-1:0];
        end else begin
            pins_r <= pins_r;
        end
    end

    // Registered read data, zero whenever no read hit this block
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= 32'h0;
        end else if (read && hit_s) begin
            rdata_r <= rd_val_s;
        end else begin
            rdata_r <= 32'h0;
        end
    end

    assign rdata = rdata_r;
    assign pins  = pins_r;

endmodule

// File: tb/tb_csr_counter_ids_pins.sv
// Directed bench for csr_counter_ids_pins: inputs driven and outputs sampled
// on the falling edge, expected values hand-computed per step.
module tb_csr_counter_ids_pins;

    logic        clk;
    logic        rst;
    logic        read;
    logic        write;
    logic [31:0] wdata;
    logic [11:0] addr;
    logic [31:0] rdata;
    logic        valid;
    logic        retired;
    logic [0:0]  pins;

    int compared;
    int mismatched;

    csr_counter_ids_pins dut (
        .clk     (clk),
        .rst     (rst),
        .read    (read),
        .write   (write),
        .wdata   (wdata),
        .addr    (addr),
        .rdata   (rdata),
        .valid   (valid),
        .retired (retired),
        .pins    (pins)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst = 1'b1; read = 1'b0; write = 1'b0; wdata = 32'h0; addr = 12'h000; retired = 1'b0;
        tick(); tick(); tick();
        check("reset_rdata", rdata, 32'h0);
        check("reset_pins", {31'h0, pins}, 32'h0);
        check("valid_unowned_000", {31'h0, valid}, 32'h0);
        addr = 12'h301; #1;
        check("valid_in_reset", {31'h0, valid}, 32'h1);

        // ID registers
        rst = 1'b0; read = 1'b1; addr = 12'h301; #1;
        check("valid_misa", {31'h0, valid}, 32'h1);
        tick();
        check("rd_misa", rdata, 32'h40001104);
        addr = 12'hF14; #1;
        check("valid_mhartid", {31'h0, valid}, 32'h1);
        tick();
        check("rd_mhartid", rdata, 32'h0);
        addr = 12'hFC0; #1;
        check("valid_khz", {31'h0, valid}, 32'h1);
        tick();
        check("rd_khz", rdata, 32'h0000000A);
        addr = 12'h7C0; #1;
        check("valid_unowned_7c0", {31'h0, valid}, 32'h0);
        tick();
        check("rd_unowned", rdata, 32'h0);
        read = 1'b0;

        // Reset mid-operation, then count 20 cycles
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        read = 1'b1; addr = 12'hB00;
        tick();
        check("rd_mcycle_20", rdata, 32'd20);
        addr = 12'hC00;
        tick();
        check("rd_cycle_21", rdata, 32'd21);
        addr = 12'hC01;
        tick();
        check("rd_time_22", rdata, 32'd22);
        read = 1'b0;
        tick();
        check("rd_idle_zero", rdata, 32'h0);

        // Retired pulses on non-consecutive cycles
        for (int i = 0; i < 5; i++) begin
            retired = 1'b1; tick();
            retired = 1'b0; tick();
        end
        read = 1'b1; addr = 12'hC02;
        tick();
        check("rd_instret_5", rdata, 32'd5);
        addr = 12'hC82;
        tick();
        check("rd_instreth_0", rdata, 32'h0);
        read = 1'b0;

        // Low-word write then carry into the high word
        write = 1'b1; addr = 12'hB00; wdata = 32'hFFFFFFFF;
        tick();
        write = 1'b0;
        tick(); tick();
        read = 1'b1; addr = 12'hB80;
        tick();
        check("rd_mcycleh_carry", rdata, 32'h1);
        addr = 12'hB00;
        tick();
        check("rd_mcycle_wrapped", rdata, 32'h2);
        // Same-cycle read and write returns the old value
        write = 1'b1; wdata = 32'h100;
        tick();
        check("rd_old_on_write", rdata, 32'h3);
        write = 1'b0;
        tick();
        check("rd_written_value", rdata, 32'h100);
        addr = 12'hB80;
        tick();
        check("rd_high_untouched", rdata, 32'h1);
        read = 1'b0;

        // Pins
        write = 1'b1; addr = 12'hBC1; wdata = 32'h1; #1;
        check("valid_pins", {31'h0, valid}, 32'h1);
        tick();
        check("pins_set", {31'h0, pins}, 32'h1);
        write = 1'b0; read = 1'b1;
        tick();
        check("rd_pins", rdata, 32'h1);
        read = 1'b0; write = 1'b1; wdata = 32'hFFFFFFFE;
        tick();
        check("pins_clear", {31'h0, pins}, 32'h0);
        wdata = 32'h1;
        tick();
        check("pins_set_again", {31'h0, pins}, 32'h1);
        rst = 1'b1;
        tick();
        check("pins_reset_over_write", {31'h0, pins}, 32'h0);
        check("rdata_in_reset", rdata, 32'h0);
        write = 1'b0; rst = 1'b0;
        tick();
        read = 1'b1; addr = 12'hB00;
        tick();
        check("rd_mcycle_after_reset", rdata, 32'h1);
        addr = 12'hC02;
        tick();
        check("rd_instret_after_reset", rdata, 32'h0);
        read = 1'b0;

        // Writes to read-only addresses are ignored
        write = 1'b1; addr = 12'h301; wdata = 32'h1234;
        tick();
        addr = 12'hC00;
        tick();
        write = 1'b0; read = 1'b1; addr = 12'h301;
        tick();
        check("rd_misa_unchanged", rdata, 32'h40001104);
        addr = 12'hC00;
        tick();
        check("rd_cycle_still_counting", rdata, 32'd6);
        read = 1'b0;
        tick();
        check("pins_unaffected", {31'h0, pins}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/csr_counter_ids_pins.md
Name: csr_counter_ids_pins

Overview:
CSR-bus peripheral combining three functions: read-only identification registers, 64-bit cycle/instret counters, and a small bank of writable output pins (software interrupt line). It sits on the core's CSR side-bus next to other CSR peripherals; every peripheral's rdata is ORed into one bus and their valids are ORed. The core sends a 12-bit CSR address with read/write strobes, and this block answers only the addresses it owns.

Parameters:
ISA, 32'h40001104, value returned by misa (RV32IMC).
IDS_BASE_ADDR, 12'hFC0, address of the clock-rate CSR.
KHZ, 10, clock frequency in kHz returned at IDS_BASE_ADDR.
PINS_BASE_ADDR, 12'hBC1, address of the pin register.
PINS_COUNT, 1, number of output pins (1..32).
PINS_RESET_VALUE, 0, pin state after reset.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  synchronous reset, active-high.
read  in  1  CSR read strobe.
write  in  1  CSR write strobe.
wdata  in  32  CSR write data.
addr  in  12  CSR address.
rdata  out  32  read data, registered; 0 unless a read hit this block in the previous cycle.
valid  out  1  combinational: 1 when addr is any address owned by this block, regardless of read/write.
retired  in  1  one instruction retired this cycle.
pins  out  PINS_COUNT  registered pin outputs.

Behaviour:
- Address map, read-only unless noted:
  - misa 0x301 = ISA.
  - mvendorid 0xF11, marchid 0xF12, mimpid 0xF13, mhartid 0xF14 = 0.
  - IDS_BASE_ADDR = KHZ.
  - mcycle 0xB00 / mcycleh 0xB80, writable.
  - minstret 0xB02 / minstreth 0xB82, writable.
  - cycle 0xC00 / cycleh 0xC80; time 0xC01 / timeh 0xC81 (alias of cycle); instret 0xC02 / instreth 0xC82.
  - PINS_BASE_ADDR, writable.
- valid = OR of all address matches, independent of read, write and reset.
- Read latency is one cycle. At a clock edge with read=1 and a hit, rdata <= value the register held before that edge (pre-increment counter value). Otherwise rdata <= 0. Bits above PINS_COUNT read 0.
- mcycle (64 bits): increments by 1 every cycle when not in reset; wraps 2^64-1 -> 0, with carry from the low word into the high word.
- minstret (64 bits): increments by 1 in each cycle where retired=1.
- Write to a counter half replaces that 32-bit half with wdata. A write wins over the increment in the same cycle; counting resumes from the written value on the next cycle. The other half is not altered by the write; no carry is applied in the write cycle.
- Write to PINS_BASE_ADDR: pins <= wdata[PINS_COUNT-1:0].
- Writes to read-only or unowned addresses are ignored; valid still follows addr.
- Simultaneous read and write to the same address: rdata returns the old value; the new value is visible from the next cycle.
- Reset (sync, rst=1), also mid-operation: counters <= 0, pins <= PINS_RESET_VALUE, rdata <= 0. Writes and increments in a reset cycle are ignored.
- No internal state other than the two counters, pins and the rdata register.

Test Plan:
- Reset, then read 0x301, 0xF14, 0xFC0 -> rdata next cycle 0x40001104, 0x00000000, 0x0000000A; valid=1 during each, and valid=0 for addr 0x7C0.
- Release reset, hold 20 cycles, read 0xB00 -> 20 (±fixed offset defined by the bench at reset release); 0xC00 and 0xC01 return the same value; rdata=0 in the cycle after read deasserts.
- Pulse retired on 5 non-consecutive cycles, read 0xC02 -> 5; read 0xC82 -> 0.
- Write 0xFFFFFFFF to 0xB00, then read 0xB80 three cycles later -> 1 (carry); read 0xB00 -> small wrapped value.
- Write 1 to 0xBC1 -> pins=1 after the edge; read 0xBC1 -> 1; write 0 -> pins=0; assert rst -> pins=PINS_RESET_VALUE.
- Write 0x1234 to 0x301 and to 0xC00 -> no change: misa still 0x40001104, cycle keeps counting.
